// File: rtl/add_req_issuer.sv
// Issues operand pairs to a fixed-latency registered adder and collects the
// results, with credit-based flow control so no adder result is ever dropped.
module add_req_issuer #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int LAT   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         add_start,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    input  logic [W-1:0] add_y,
    input  logic         add_valid,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic [7:0]   out_seq,
    output logic         err_unexpected,
    output logic         err_missing,
    output logic         busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic          run;
    logic [OW-1:0] occ;
    logic [7:0]    seq;
    logic [7:0]    tag;

    logic [LAT-1:0] pexp;
    logic [7:0]     pseq [LAT];

    logic [W-1:0]  mem_sum [DEPTH];
    logic [7:0]    mem_seq [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] cnt;

    logic accept;
    logic pop;
    logic tail_exp;
    logic push;
    logic miss;
    logic take;
    logic direct;
    logic mem_wr;
    logic mem_rd;

    assign in_ready = run && (occ < OW'(DEPTH));
    assign busy     = (occ != '0);
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign tail_exp = pexp[LAT-1];
    assign push     = tail_exp && add_valid;
    assign miss     = tail_exp && !add_valid;
    assign take     = !out_valid || out_ready;
    // An empty backing store lets a fresh result go straight to the head register.
    assign direct   = take && (cnt == '0) && push;
    assign mem_wr   = push && !direct;
    assign mem_rd   = take && (cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            occ       <= '0;
            seq       <= '0;
            tag       <= '0;
            add_start <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
        end else begin
            run       <= 1'b1;
            occ       <= occ + OW'(accept) - OW'(pop) - OW'(miss);
            add_start <= accept;
            if (accept) begin
                add_a <= in_a;
                add_b <= in_b;
                tag   <= seq;
                seq   <= seq + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pexp <= '0;
            for (int i = 0; i < LAT; i++) pseq[i] <= '0;
        end else begin
            pexp[0] <= add_start;
            pseq[0] <= tag;
            for (int i = 1; i < LAT; i++) begin
                pexp[i] <= pexp[i-1];
                pseq[i] <= pseq[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_unexpected <= 1'b0;
            err_missing    <= 1'b0;
        end else begin
            if (add_valid && !tail_exp) err_unexpected <= 1'b1;
            if (miss) err_missing <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem_sum[wr_ptr] <= add_y;
            mem_seq[wr_ptr] <= pseq[LAT-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_seq   <= '0;
        end else begin
            if (mem_wr) wr_ptr <= wr_ptr + AW'(1);
            if (mem_rd) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + OW'(mem_wr) - OW'(mem_rd);
            if (take) begin
                if (cnt != '0) begin
                    out_valid <= 1'b1;
                    out_sum   <= mem_sum[rd_ptr];
                    out_seq   <= mem_seq[rd_ptr];
                end else if (push) begin
                    out_valid <= 1'b1;
                    out_sum   <= add_y;
                    out_seq   <= pseq[LAT-1];
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_add_req_issuer.sv
// Bench for add_req_issuer: behavioural adder plus a timestamped result-queue
// reference model, randomized traffic and directed corner cases.
module tb_add_req_issuer;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         add_start;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic [W-1:0] add_y;
    logic         add_valid;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic [7:0]   out_seq;
    logic         err_unexpected;
    logic         err_missing;
    logic         busy;

    always #5 clk = ~clk;

    add_req_issuer #(.W(W), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_y(add_y), .add_valid(add_valid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_seq(out_seq),
        .err_unexpected(err_unexpected), .err_missing(err_missing), .busy(busy)
    );

    // Behavioural adder with hooks to drop one tagged result or inject a stray one.
    logic         sup_en;
    logic [7:0]   sup_seq;
    logic         spur;
    logic [LAT-1:0] av;
    logic [W-1:0] ay [LAT];
    logic [7:0]   aseq [LAT];
    logic [7:0]   acnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            av   <= '0;
            acnt <= '0;
            for (int i = 0; i < LAT; i++) begin
                ay[i]   <= '0;
                aseq[i] <= '0;
            end
        end else begin
            av[0]   <= add_start;
            ay[0]   <= add_a + add_b;
            aseq[0] <= acnt;
            if (add_start) acnt <= acnt + 8'd1;
            for (int i = 1; i < LAT; i++) begin
                av[i]   <= av[i-1];
                ay[i]   <= ay[i-1];
                aseq[i] <= aseq[i-1];
            end
        end
    end

    assign add_valid = (av[LAT-1] && !(sup_en && aseq[LAT-1] == sup_seq)) || spur;
    assign add_y     = ay[LAT-1];

    typedef struct {
        logic [W-1:0] sum;
        logic [7:0]   seq;
        int           rdy;
    } exp_t;

    exp_t         exq[$];
    int           miss_q[$];
    int           cyc;
    int           occ_m;
    bit           run_m;
    bit           iss_m;
    logic [W-1:0] ia_m;
    logic [W-1:0] ib_m;
    logic [7:0]   seq_m;
    bit           errm_m;
    bit           erru_m;
    int           checks;
    int           errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        exq.delete();
        miss_q.delete();
        occ_m  = 0;
        run_m  = 0;
        iss_m  = 0;
        seq_m  = 0;
        errm_m = 0;
        erru_m = 0;
    endtask

    // Called at a negedge with inputs already driven; checks, then advances one cycle.
    task automatic tick();
        bit           acc;
        bit           pp;
        bit           sp;
        bit           ov;
        logic [W-1:0] ca;
        logic [W-1:0] cb;
        logic [W-1:0] s;
        ov = (exq.size() != 0) && (exq[0].rdy <= cyc);
        check("in_ready", in_ready, run_m && occ_m < DEPTH);
        check("busy", busy, occ_m != 0);
        check("add_start", add_start, iss_m);
        if (iss_m) begin
            check("add_a", add_a, ia_m);
            check("add_b", add_b, ib_m);
        end
        check("out_valid", out_valid, ov);
        if (ov) begin
            check("out_sum", out_sum, exq[0].sum);
            check("out_seq", out_seq, exq[0].seq);
        end
        check("err_missing", err_missing, errm_m);
        check("err_unexpected", err_unexpected, erru_m);
        acc = in_valid && in_ready;
        pp  = out_valid && out_ready;
        sp  = spur;
        ca  = in_a;
        cb  = in_b;
        @(posedge clk);
        cyc++;
        iss_m = acc;
        if (pp && exq.size() != 0) begin
            void'(exq.pop_front());
            occ_m--;
        end
        if (acc) begin
            ia_m = ca;
            ib_m = cb;
            s = ca + cb;
            if (sup_en && seq_m == sup_seq) miss_q.push_back(cyc + 3);
            else exq.push_back('{sum: s, seq: seq_m, rdy: cyc + 3});
            occ_m++;
            seq_m++;
        end
        while (miss_q.size() != 0 && miss_q[0] == cyc) begin
            void'(miss_q.pop_front());
            occ_m--;
            errm_m = 1;
        end
        if (sp) erru_m = 1;
        run_m = 1;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        spur      = 1'b0;
        sup_en    = 1'b0;
        model_clear();
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_add_start", add_start, 0);
        check("rst_add_ab", {add_a, add_b}, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_seq", out_seq, 0);
        check("rst_errs", {err_unexpected, err_missing}, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        int nacc;
        int idx;
        int k;
        checks = 0;
        errors = 0;
        cyc    = 0;
        in_a   = '0;
        in_b   = '0;
        sup_seq = '0;
        reset_dut();

        // Single op latency, then wrap.
        tick();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 16'h0003; in_b = 16'h0004;
        tick();
        in_valid = 1'b0;
        k = 1;
        while (!out_valid && k < 10) begin
            tick();
            k++;
        end
        check("single_latency", k, 4);
        check("single_sum", out_sum, 16'h0007);
        check("single_seq", out_seq, 8'h00);
        drain(3);
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001;
        tick();
        in_valid = 1'b0;
        drain(6);
        check("no_errors", {err_unexpected, err_missing}, 0);

        // Backpressure: only DEPTH credits.
        reset_dut();
        tick();
        out_ready = 1'b0;
        nacc = 0;
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_a = W'(idx + 10); in_b = W'(idx);
            if (in_ready) begin
                nacc++;
                idx++;
            end
            tick();
        end
        check("bp_accepts", nacc, 4);
        check("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 30 && idx < 6; i++) begin
            in_valid = 1'b1; in_a = W'(idx + 10); in_b = W'(idx);
            if (in_ready) idx++;
            tick();
        end
        check("bp_rest_accepted", idx, 6);
        drain(10);

        // Spurious return while idle.
        reset_dut();
        tick();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        tick();
        check("spur_flag", err_unexpected, 1);
        check("spur_out_valid", out_valid, 0);
        check("spur_busy", busy, 0);

        // Missing return for seq 2 of 4.
        reset_dut();
        tick();
        sup_en = 1'b1; sup_seq = 8'd2;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
            tick();
        end
        drain(10);
        sup_en = 1'b0;
        check("miss_flag", err_missing, 1);
        check("miss_busy", busy, 0);
        check("miss_in_ready", in_ready, 1);

        // Reset with ops in flight.
        reset_dut();
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
            tick();
        end
        reset_dut();
        tick();
        check("rst_release_in_ready", in_ready, 1);
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h0001;
        tick();
        drain(6);

        // 257 ops to wrap the sequence tag.
        reset_dut();
        tick();
        out_ready = 1'b1;
        nacc = 0;
        for (int i = 0; i < 400 && nacc < 257; i++) begin
            in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
            if (in_ready) nacc++;
            tick();
        end
        check("wrap_ops", nacc, 257);
        drain(6);

        // Randomized traffic with random backpressure.
        reset_dut();
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
            in_b = W'($urandom);
            tick();
        end
        drain(12);
        check("rand_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
